// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the UART ALU command protocol: state encodings
// exposed on the debug LEDs and the default byte width.
package alu_cmd_pkg;

    localparam int DEFAULT_NBIT = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEND_A  = 3'd1;
    localparam logic [2:0] ST_SEND_B  = 3'd2;
    localparam logic [2:0] ST_SEND_OP = 3'd3;
    localparam logic [2:0] ST_WAIT_RX = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SEND_A  = ST_SEND_A,
        SEND_B  = ST_SEND_B,
        SEND_OP = ST_SEND_OP,
        WAIT_RX = ST_WAIT_RX,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/alu_cmd_initiator.sv
// Host-side initiator: pushes A, B, OP into the UART TX FIFO, then waits
// (with a timeout) for the single result byte from the RX FIFO.
module alu_cmd_initiator
    import alu_cmd_pkg::*;
#(
    parameter int NBIT    = DEFAULT_NBIT,
    parameter int TIMEOUT = 1000000,
    parameter int TO_BITS = 20
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [NBIT-1:0] op_a,
    input  logic [NBIT-1:0] op_b,
    input  logic [NBIT-1:0] opcode,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [NBIT-1:0] w_data,
    input  logic            rx_empty,
    input  logic [NBIT-1:0] r_data,
    output logic            rd_uart,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [NBIT-1:0] result,
    output logic [2:0]      state
);

    localparam logic [TO_BITS-1:0] LIMIT = TO_BITS'(TIMEOUT - 1);

    state_t             state_q;
    logic [NBIT-1:0]    opA_q;
    logic [NBIT-1:0]    opB_q;
    logic [NBIT-1:0]    opcode_q;
    logic [NBIT-1:0]    result_q;
    logic [TO_BITS-1:0] count_q;
    logic               done_q;
    logic               timeout_q;

    // Each SEND state advances only on a cycle where its byte is actually pushed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            opcode_q  <= '0;
            result_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q    <= op_a;
                        opB_q    <= op_b;
                        opcode_q <= opcode;
                        state_q  <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (!tx_full) state_q <= SEND_B;
                end
                SEND_B: begin
                    if (!tx_full) state_q <= SEND_OP;
                end
                SEND_OP: begin
                    if (!tx_full) begin
                        count_q <= '0;
                        state_q <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    // A reply arriving on the limit cycle still completes normally.
                    if (!rx_empty) begin
                        result_q <= r_data;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (count_q == LIMIT) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO strobes; reads in IDLE drain stale replies from aborted transactions.
    always_comb begin
        wr_uart = 1'b0;
        w_data  = opA_q;
        rd_uart = 1'b0;
        case (state_q)
            SEND_A: begin
                wr_uart = ~tx_full;
            end
            SEND_B: begin
                wr_uart = ~tx_full;
                if (!tx_full) w_data = opB_q;
            end
            SEND_OP: begin
                wr_uart = ~tx_full;
                if (!tx_full) w_data = opcode_q;
            end
            IDLE, WAIT_RX: begin
                rd_uart = ~rx_empty;
            end
            default: begin
                rd_uart = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign timeout = timeout_q;
    assign result  = result_q;
    assign state   = state_q;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench for alu_cmd_initiator: table-driven transactions with a
// small FIFO/responder model, plus reset and idle-drain sequences.
module tb_alu_cmd_initiator;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] opcode;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] result;
    logic [2:0] state;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] reply;
        int         txFullFrom;
        int         txFullLen;
        int         replyCycle;
        int         startHold;
        int         expPush0;
        int         expPush1;
        int         expPush2;
        int         expDone;
        int         expTimeout;
        logic [7:0] expResult;
        int         expPops;
    } vec_t;

    vec_t vecs[6];

    alu_cmd_initiator #(
        .NBIT    (8),
        .TIMEOUT (16),
        .TO_BITS (5)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .opcode   (opcode),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .result   (result),
        .state    (state)
    );

    // 10-unit clock period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Runs one transaction row for a fixed 30-cycle window; cycle 0 is the start cycle.
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   nPush;
        int   pushCyc[3];
        int   pushByte[3];
        int   doneCyc;
        int   doneCnt;
        int   toCyc;
        int   toCnt;
        int   pops;
        int   holdErr;
        int   busyAtTo;
        bit   popped;
        v = vecs[idx];
        nPush = 0;
        for (int i = 0; i < 3; i++) begin
            pushCyc[i]  = -1;
            pushByte[i] = -1;
        end
        doneCyc = -1; doneCnt = 0; toCyc = -1; toCnt = 0;
        pops = 0; holdErr = 0; busyAtTo = 1; popped = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge CLK);
            start    = (cyc < v.startHold);
            op_a     = v.a;
            op_b     = v.b;
            opcode   = v.op;
            tx_full  = (v.txFullLen > 0) && (cyc >= v.txFullFrom) && (cyc < v.txFullFrom + v.txFullLen);
            rx_empty = !((v.replyCycle >= 0) && (cyc >= v.replyCycle) && !popped);
            r_data   = v.reply;
            #1;
            if (wr_uart) begin
                if (nPush < 3) begin
                    pushCyc[nPush]  = cyc;
                    pushByte[nPush] = int'(w_data);
                end
                nPush++;
            end else if (cyc >= 1 && cyc <= v.expPush2 && w_data !== v.a) begin
                holdErr++;
            end
            if (rd_uart) begin
                pops++;
                if (!rx_empty) popped = 1'b1;
            end
            if (done) begin
                if (doneCnt == 0) doneCyc = cyc;
                doneCnt++;
            end
            if (timeout) begin
                if (toCnt == 0) begin
                    toCyc    = cyc;
                    busyAtTo = int'(busy);
                end
                toCnt++;
            end
        end
        @(negedge CLK);
        start    = 1'b0;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        #1;
        checkOutput($sformatf("row%0d push_count", idx), nPush, 3);
        checkOutput($sformatf("row%0d push_A", idx), pushByte[0], int'(v.a));
        checkOutput($sformatf("row%0d push_B", idx), pushByte[1], int'(v.b));
        checkOutput($sformatf("row%0d push_OP", idx), pushByte[2], int'(v.op));
        checkOutput($sformatf("row%0d cycle_A", idx), pushCyc[0], v.expPush0);
        checkOutput($sformatf("row%0d cycle_B", idx), pushCyc[1], v.expPush1);
        checkOutput($sformatf("row%0d cycle_OP", idx), pushCyc[2], v.expPush2);
        checkOutput($sformatf("row%0d wdata_hold", idx), holdErr, 0);
        checkOutput($sformatf("row%0d done_cycle", idx), doneCyc, v.expDone);
        checkOutput($sformatf("row%0d done_count", idx), doneCnt, (v.expDone >= 0) ? 1 : 0);
        checkOutput($sformatf("row%0d timeout_cycle", idx), toCyc, v.expTimeout);
        checkOutput($sformatf("row%0d timeout_count", idx), toCnt, (v.expTimeout >= 0) ? 1 : 0);
        if (v.expTimeout >= 0)
            checkOutput($sformatf("row%0d busy_at_timeout", idx), busyAtTo, 0);
        checkOutput($sformatf("row%0d result", idx), int'(result), int'(v.expResult));
        checkOutput($sformatf("row%0d pops", idx), pops, v.expPops);
        checkOutput($sformatf("row%0d end_state", idx), int'(state), 0);
        checkOutput($sformatf("row%0d end_busy", idx), int'(busy), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // a, b, op, reply, txFrom, txLen, replyCyc, startHold, pA, pB, pOP, done, timeout, result, pops
        vecs[0] = '{8'h12, 8'h34, 8'h20, 8'h46, 0, 0,  6, 1, 1, 2, 3,  7, -1, 8'h46, 1};
        vecs[1] = '{8'hA5, 8'h0F, 8'h01, 8'hAA, 2, 5, 11, 1, 1, 7, 8, 12, -1, 8'hAA, 1};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h03, 1, 2,  6, 3, 3, 4, 5,  7, -1, 8'h03, 1};
        vecs[3] = '{8'h7F, 8'h80, 8'h10, 8'hEE, 0, 0, 19, 1, 1, 2, 3, 20, -1, 8'hEE, 1};
        vecs[4] = '{8'h11, 8'h22, 8'h33, 8'h00, 0, 0, -1, 1, 1, 2, 3, -1, 20, 8'hEE, 0};
        vecs[5] = '{8'hC3, 8'h3C, 8'h99, 8'h5A, 0, 0,  7, 1, 1, 2, 3,  8, -1, 8'h5A, 1};

        RESET    = 1'b1;
        start    = 1'b0;
        op_a     = 8'h00;
        op_b     = 8'h00;
        opcode   = 8'h00;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;

        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_timeout", int'(timeout), 0);
        checkOutput("reset_result", int'(result), 0);
        checkOutput("reset_wr_uart", int'(wr_uart), 0);
        checkOutput("reset_rd_uart", int'(rd_uart), 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Stale byte in the RX FIFO while idle is drained without completing
        @(negedge CLK);
        rx_empty = 1'b0;
        r_data   = 8'h55;
        #1;
        checkOutput("drain_rd_uart", int'(rd_uart), 1);
        @(negedge CLK);
        rx_empty = 1'b1;
        #1;
        checkOutput("drain_rd_uart_after", int'(rd_uart), 0);
        checkOutput("drain_done", int'(done), 0);
        checkOutput("drain_result", int'(result), 0);
        checkOutput("drain_state", int'(state), 0);

        for (int i = 0; i < 5; i++) applyStimulus(i);

        // Reset asserted mid-transaction while sending B
        @(negedge CLK);
        start  = 1'b1;
        op_a   = 8'hDE;
        op_b   = 8'hAD;
        opcode = 8'hBE;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("midreset_pre_state", int'(state), 2);
        checkOutput("midreset_pre_wdata", int'(w_data), 8'hAD);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("midreset_state", int'(state), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_wr_uart", int'(wr_uart), 0);
        checkOutput("midreset_result", int'(result), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_timeout", int'(timeout), 0);
        @(negedge CLK);
        RESET = 1'b0;

        applyStimulus(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
